// File: rtl/led_grant_arbiter_if.sv
// led_grant_arbiter_if: switch-to-LED bus between the board pins and the grant arbiter
// Signals: i_Switch raw switch levels (1 = request); o_Grant one-hot LED grant;
//          o_Busy any grant asserted; o_Req filtered request vector (debug)
// Modports: master drives switches and observes grants, slave is the arbiter side
interface led_grant_arbiter_if #(parameter int NUM_REQ = 4);
  logic [NUM_REQ-1:0] i_Switch;
  logic [NUM_REQ-1:0] o_Grant;
  logic [NUM_REQ-1:0] o_Req;
  logic               o_Busy;
  modport master (output i_Switch, input o_Grant, o_Busy, o_Req);
  modport slave  (input i_Switch, output o_Grant, o_Busy, o_Req);
endinterface

// File: rtl/led_grant_arbiter.sv
// led_grant_arbiter: round-robin owner of the LED bank among synchronised, optionally debounced switches
// Ports: i_Clk rising-edge clock; i_Rst_L async active-low reset;
//        bus (slave): i_Switch in, o_Grant / o_Busy / o_Req registered outputs
// Option: define DEBOUNCE_EN to insert a DEBOUNCE_LIMIT-cycle stability filter per channel
module led_grant_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int CLKS_PER_SLICE = 25000000
) (
  input logic               i_Clk,
  input logic               i_Rst_L,
  led_grant_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  localparam int OW = $clog2(NUM_REQ);
  localparam int SW = CLKS_PER_SLICE > 1 ? $clog2(CLKS_PER_SLICE) : 1;
  logic [NUM_REQ-1:0] s1_q, s2_q, r, req_q, grant_q, grant_d;
  logic               busy_q, busy_d, sel_vld, sat, others;
  state_t             state_q, state_d;
  logic [OW-1:0]      owner_q, owner_d, last_q, last_d, sel;
  logic [SW-1:0]      slice_q, slice_d;
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) {s2_q, s1_q} <= '0;
    else {s2_q, s1_q} <= {s1_q, bus.i_Switch};
  end
`ifdef DEBOUNCE_EN
  localparam int DW = DEBOUNCE_LIMIT > 1 ? $clog2(DEBOUNCE_LIMIT) : 1;
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_db
    logic [DW-1:0] cnt_q;
    logic          stable_q, mis, hit;
    assign mis  = s2_q[g] ^ stable_q;
    // the cycle the mismatch has lasted DEBOUNCE_LIMIT cycles the new level is accepted
    assign hit  = mis && cnt_q == DW'(DEBOUNCE_LIMIT - 1);
    assign r[g] = stable_q;
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        cnt_q    <= '0;
        stable_q <= 1'b0;
      end else begin
        cnt_q    <= (mis && !hit) ? cnt_q + 1'b1 : '0;
        stable_q <= stable_q ^ hit;
      end
    end
  end
`else
  assign r = s2_q;
`endif
  // round-robin pick: descending scan so the nearest requester after last_q wins
  always_comb begin
    sel     = last_q;
    sel_vld = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (r[(int'(last_q) + i) % NUM_REQ]) begin
        sel     = OW'((int'(last_q) + i) % NUM_REQ);
        sel_vld = 1'b1;
      end
    end
  end
  assign sat    = slice_q == SW'(CLKS_PER_SLICE - 1);
  assign others = |(r & ~grant_q);
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    slice_d = (state_q == GRANT && !sat) ? slice_q + 1'b1 : slice_q;
    if (state_q == IDLE && sel_vld) begin
      state_d = GRANT;
      owner_d = sel;
      last_d  = sel;
      slice_d = '0;
    end else if (state_q == GRANT && (!r[owner_q] || (sat && others))) begin
      state_d = GAP;
    end else if (state_q == GAP) begin
      state_d = IDLE;
    end
  end
  always_comb begin
    grant_d = (state_d == GRANT) ? NUM_REQ'(1) << owner_d : '0;
    busy_d  = state_d == GRANT;
  end
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= OW'(NUM_REQ - 1);
      slice_q <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      slice_q <= slice_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      req_q   <= r;
    end
  end
  assign bus.o_Grant = grant_q;
  assign bus.o_Busy  = busy_q;
  assign bus.o_Req   = req_q;
endmodule

// File: tb/tb_led_grant_arbiter.sv
// tb_led_grant_arbiter: randomized switch traffic against a behavioural arbiter model plus pinned scenarios
module tb_led_grant_arbiter;
  localparam int N = 4, DL = 4, CPS = 8;
`ifdef DEBOUNCE_EN
  localparam int LAT = 2 + DL;
`else
  localparam int LAT = 2;
`endif
  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0, miscompares = 0;
  led_grant_arbiter_if #(.NUM_REQ(N)) bus ();
  led_grant_arbiter #(.NUM_REQ(N), .DEBOUNCE_LIMIT(DL), .CLKS_PER_SLICE(CPS)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask
  // model: owner index (-1 none), cycles granted so far, one dead cycle after a release
  int m_owner = -1, m_held = 0, m_cool = 0, m_last = N - 1;
  logic [N-1:0] m_s1 = '0, m_s2 = '0, m_stab = '0, e_grant = '0, e_req = '0;
  logic e_busy = 1'b0;
  logic [N-1:0] m_hist [DL];
  always @(posedge clk or negedge rst_n) begin
    logic [N-1:0] r;
    bit flip;
    if (!rst_n) begin
      m_owner = -1; m_held = 0; m_cool = 0; m_last = N - 1;
      m_s1 = '0; m_s2 = '0; m_stab = '0;
      e_grant = '0; e_req = '0; e_busy = 1'b0;
      for (int j = 0; j < DL; j++) m_hist[j] = '0;
    end else begin
`ifdef DEBOUNCE_EN
      r = m_stab;
`else
      r = m_s2;
`endif
      e_req = r;
      if (m_owner >= 0) begin
        if (!r[m_owner] || (m_held >= CPS && (r & ~(N'(1) << m_owner)) != '0)) begin
          m_owner = -1;
          m_cool  = 1;
        end else m_held++;
      end else if (m_cool > 0) m_cool = 0;
      else if (r != '0) begin
        for (int i = 1; i <= N; i++) if (m_owner < 0 && r[(m_last + i) % N]) m_owner = (m_last + i) % N;
        m_last = m_owner;
        m_held = 1;
      end
      e_grant = (m_owner >= 0) ? N'(1) << m_owner : '0;
      e_busy  = e_grant != '0;
`ifdef DEBOUNCE_EN
      // a level is accepted once the last DL synced samples all disagree with the accepted level
      for (int j = DL - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = m_s2;
      for (int k = 0; k < N; k++) begin
        flip = 1'b1;
        for (int j = 0; j < DL; j++) if (m_hist[j][k] == m_stab[k]) flip = 1'b0;
        if (flip) m_stab[k] = ~m_stab[k];
      end
`endif
      m_s2 = m_s1;
      m_s1 = bus.i_Switch;
    end
  end
  always @(negedge clk) begin
    check("grant", bus.o_Grant, e_grant);
    check("busy", N'(bus.o_Busy), N'(e_busy));
    check("req", bus.o_Req, e_req);
  end
  initial begin
    rst_n = 1'b0;
    bus.i_Switch = '0;
    repeat (6) begin
      @(negedge clk);
      bus.i_Switch = N'($urandom);
    end
    @(negedge clk);
    bus.i_Switch = 4'b1001;
    rst_n = 1'b1;
    repeat (LAT) @(negedge clk);
    check("lit_pre_grant", bus.o_Grant, 4'b0000);
    @(negedge clk);
    check("lit_first_grant", bus.o_Grant, 4'b0001);
    repeat (7) @(negedge clk);
    check("lit_slice_hold0", bus.o_Grant, 4'b0001);
    @(negedge clk);
    check("lit_gap0", bus.o_Grant, 4'b0000);
    @(negedge clk);
    check("lit_idle0", bus.o_Grant, 4'b0000);
    @(negedge clk);
    check("lit_rotate3", bus.o_Grant, 4'b1000);
    repeat (7) @(negedge clk);
    check("lit_slice_hold3", bus.o_Grant, 4'b1000);
    @(negedge clk);
    check("lit_gap3", bus.o_Grant, 4'b0000);
    @(negedge clk);
    check("lit_idle3", bus.o_Grant, 4'b0000);
    @(negedge clk);
    check("lit_back_to0", bus.o_Grant, 4'b0001);
    bus.i_Switch = 4'b0100;
    repeat (LAT + 1) @(negedge clk);
    check("lit_release_gap", bus.o_Grant, 4'b0000);
    @(negedge clk);
    check("lit_release_idle", bus.o_Grant, 4'b0000);
    @(negedge clk);
    check("lit_release_next", bus.o_Grant, 4'b0100);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check("lit_async_grant", bus.o_Grant, 4'b0000);
    check("lit_async_busy", N'(bus.o_Busy), 4'b0000);
    bus.i_Switch = 4'b0101;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 1) @(negedge clk);
    check("lit_post_reset_first", bus.o_Grant, 4'b0001);
    bus.i_Switch = '0;
    repeat (12) @(negedge clk);
`ifdef DEBOUNCE_EN
    repeat (2) begin
      bus.i_Switch = 4'b0100;
      repeat (3) @(negedge clk);
      bus.i_Switch = 4'b0000;
      repeat (3) @(negedge clk);
    end
    bus.i_Switch = 4'b0100;
    repeat (6) @(negedge clk);
    check("lit_glitch_req_low", bus.o_Req, 4'b0000);
    @(negedge clk);
    check("lit_glitch_req", bus.o_Req, 4'b0100);
    check("lit_glitch_grant", bus.o_Grant, 4'b0100);
`else
    bus.i_Switch = 4'b0010;
    @(negedge clk);
    bus.i_Switch = 4'b0000;
    repeat (2) @(negedge clk);
    check("lit_pulse_req", bus.o_Req, 4'b0010);
    check("lit_pulse_grant", bus.o_Grant, 4'b0010);
    @(negedge clk);
    check("lit_pulse_gap", bus.o_Grant, 4'b0000);
`endif
    bus.i_Switch = '0;
    repeat (12) @(negedge clk);
    repeat (250) begin
      bus.i_Switch = N'($urandom);
      repeat ($urandom_range(1, ($urandom_range(0, 3) == 0) ? 40 : 10)) @(negedge clk);
      if ($urandom_range(0, 39) == 0) begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
